// File: rtl/mac_vector_source_if.sv
// A/B operand streams sent to the MAC and the R result stream coming back from it.
// The master modport is the vector source; the slave modport is the MAC side.
interface mac_vector_source_if #(
    parameter int WA = 12,
    parameter int WB = 8,
    parameter int WR = 45
);
    logic [WA-1:0] A_data;
    logic          A_valid;
    logic          A_ready;
    logic          A_last;

    logic [WB-1:0] B_data;
    logic          B_valid;
    logic          B_ready;
    logic          B_last;

    logic [WR-1:0] R_data;
    logic          R_valid;
    logic          R_ready;
    logic          R_last;

    modport master (
        output A_data, A_valid, A_last,
        input  A_ready,
        output B_data, B_valid, B_last,
        input  B_ready,
        input  R_data, R_valid, R_last,
        output R_ready
    );

    modport slave (
        input  A_data, A_valid, A_last,
        output A_ready,
        input  B_data, B_valid, B_last,
        output B_ready,
        output R_data, R_valid, R_last,
        input  R_ready
    );
endinterface

// File: rtl/mac_vector_source.sv
// Streams two buffered vectors (A, B) into a MAC and captures the dot-product result.
// Optional WAIT_RES watchdog is enabled by defining MAC_SRC_TIMEOUT_EN.
module mac_vector_source #(
    parameter int WA    = 12,
    parameter int WB    = 8,
    parameter int WR    = 45,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [WA-1:0] wr_a,
    input  logic [WB-1:0] wr_b,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic [WR-1:0] result,
    mac_vector_source_if.master mac
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SEND     = 2'd1;
    localparam logic [1:0] WAIT_RES = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [AW-1:0] last_idx_reg;
    logic [AW-1:0] a_idx_reg, b_idx_reg;
    logic          a_valid_reg, b_valid_reg;
    logic          a_done_reg, b_done_reg;
    logic [WR-1:0] result_reg;
    logic          cfg_err_reg;

    logic [WA-1:0] mem_a [DEPTH];
    logic [WB-1:0] mem_b [DEPTH];
    logic [WA-1:0] a_q;
    logic [WB-1:0] b_q;

    logic          len_ok, start_ok, start_bad, timeout_hit;
    logic          a_fire, b_fire, a_is_last, b_is_last;
    logic          a_done_next, b_done_next;
    logic [AW-1:0] a_rd_addr, b_rd_addr;

    assign len_ok    = (len != '0) && (len <= (AW+1)'(DEPTH));
    assign start_ok  = (state_reg == IDLE) && start && len_ok;
    assign start_bad = (state_reg == IDLE) && start && !len_ok;

    assign a_fire      = a_valid_reg && mac.A_ready;
    assign b_fire      = b_valid_reg && mac.B_ready;
    assign a_is_last   = (a_idx_reg == last_idx_reg);
    assign b_is_last   = (b_idx_reg == last_idx_reg);
    assign a_done_next = a_done_reg || (a_fire && a_is_last);
    assign b_done_next = b_done_reg || (b_fire && b_is_last);

    // Read one element ahead on acceptance so the next element lands the following cycle.
    assign a_rd_addr = a_idx_reg + AW'(a_fire);
    assign b_rd_addr = b_idx_reg + AW'(b_fire);

    always_ff @(posedge clk) begin
        if (wr_en && (state_reg == IDLE)) begin
            mem_a[wr_addr] <= wr_a;
            mem_b[wr_addr] <= wr_b;
        end
        a_q <= mem_a[a_rd_addr];
        b_q <= mem_b[b_rd_addr];
    end

`ifdef MAC_SRC_TIMEOUT_EN
    logic [15:0] to_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || (state_reg != WAIT_RES)) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + 16'd1;
        end
    end

    // Fires on the 65535th consecutive WAIT_RES cycle that has no closing beat.
    assign timeout_hit = (state_reg == WAIT_RES) && !(mac.R_valid && mac.R_last)
                         && (to_cnt_reg == 16'hFFFE);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (start_ok) state_next = SEND;
            SEND:     if (a_done_next && b_done_next) state_next = WAIT_RES;
            WAIT_RES: begin
                if (mac.R_valid && mac.R_last) state_next = DONE;
                else if (timeout_hit)          state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            last_idx_reg <= '0;
            a_idx_reg    <= '0;
            b_idx_reg    <= '0;
            a_valid_reg  <= 1'b0;
            b_valid_reg  <= 1'b0;
            a_done_reg   <= 1'b0;
            b_done_reg   <= 1'b0;
            result_reg   <= '0;
            cfg_err_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cfg_err_reg <= start_bad || timeout_hit;

            if (start_ok) begin
                last_idx_reg <= AW'(len - 1'b1);
                a_idx_reg    <= '0;
                b_idx_reg    <= '0;
                a_done_reg   <= 1'b0;
                b_done_reg   <= 1'b0;
                a_valid_reg  <= 1'b0;
                b_valid_reg  <= 1'b0;
            end else if (state_reg == SEND) begin
                if (a_fire && !a_is_last) a_idx_reg <= a_idx_reg + 1'b1;
                if (b_fire && !b_is_last) b_idx_reg <= b_idx_reg + 1'b1;
                a_done_reg  <= a_done_next;
                b_done_reg  <= b_done_next;
                // Valid rises one cycle into SEND, once the first read has completed.
                a_valid_reg <= !a_done_next;
                b_valid_reg <= !b_done_next;
            end else begin
                a_valid_reg <= 1'b0;
                b_valid_reg <= 1'b0;
            end

            if ((state_reg == WAIT_RES) && mac.R_valid) begin
                result_reg <= mac.R_data;
            end
        end
    end

    assign mac.A_data  = a_q;
    assign mac.A_valid = a_valid_reg;
    assign mac.A_last  = a_valid_reg && a_is_last;
    assign mac.B_data  = b_q;
    assign mac.B_valid = b_valid_reg;
    assign mac.B_last  = b_valid_reg && b_is_last;
    assign mac.R_ready = (state_reg == WAIT_RES);

    assign busy    = (state_reg == SEND) || (state_reg == WAIT_RES);
    assign done    = (state_reg == DONE);
    assign cfg_err = cfg_err_reg;
    assign result  = result_reg;
endmodule

// File: tb/tb_mac_vector_source.sv
// Randomised bench for mac_vector_source; a buffer/dot-product model in the bench
// plays the MAC and predicts every streamed element and the captured result.
module tb_mac_vector_source;
    localparam int WA = 12, WB = 8, WR = 45, DEPTH = 16, AW = 4;

    logic          clk = 1'b0;
    logic          reset, wr_en, start;
    logic [AW-1:0] wr_addr;
    logic [WA-1:0] wr_a;
    logic [WB-1:0] wr_b;
    logic [AW:0]   len;
    logic          busy, done, cfg_err;
    logic [WR-1:0] result;

    mac_vector_source_if #(.WA(WA), .WB(WB), .WR(WR)) mac ();

    mac_vector_source #(.WA(WA), .WB(WB), .WR(WR), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a),
        .wr_b(wr_b), .start(start), .len(len), .busy(busy), .done(done),
        .cfg_err(cfg_err), .result(result), .mac(mac)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [WA-1:0] ref_a [DEPTH];
    logic [WB-1:0] ref_b [DEPTH];
    bit op_active = 0;
    int a_last_k, b_last_k;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic pick(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return k[0];
        return 1'($urandom_range(0, 1));
    endfunction

    // Buffer writes only take effect while no operation is running.
    task automatic write_word(input int addr, input logic [WA-1:0] a, input logic [WB-1:0] b);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_a = a; wr_b = b;
        @(negedge clk);
        wr_en = 1'b0;
        if (!op_active) begin ref_a[addr] = a; ref_b[addr] = b; end
    endtask

    task automatic run_op(input int n, input int a_mode, input int b_mode, input bit poke);
        int a_cnt = 0, b_cnt = 0, k = 1;
        bit a_pend = 0, b_pend = 0, entered = 0;
        logic [WA-1:0] a_prev = '0;
        logic [WB-1:0] b_prev = '0;
        longint acc = 0;
        logic [WR-1:0] rexp, v;
        int nb;
        a_last_k = -1; b_last_k = -1;
        @(negedge clk);
        start = 1'b1; len = (AW+1)'(n); op_active = 1;
        @(negedge clk);
        start = 1'b0;
        while (k < 200) begin
            mac.A_ready = pick(a_mode, k);
            mac.B_ready = pick(b_mode, k);
            wr_en = 1'b0; start = 1'b0;
            if (poke && k == 2) begin
                wr_en = 1'b1; wr_addr = '0; wr_a = WA'($urandom); wr_b = WB'($urandom);
            end
            if (poke && k == 3) begin start = 1'b1; len = '0; end
            #1;
            if (poke && k == 4) check("busy_start_no_err", cfg_err, 0);
            if (mac.R_ready) begin entered = 1; break; end
            if (a_pend) check("a_hold", {mac.A_valid, mac.A_data}, {1'b1, a_prev});
            if (b_pend) check("b_hold", {mac.B_valid, mac.B_data}, {1'b1, b_prev});
            if (mac.A_valid && mac.A_ready) begin
                if (a_cnt < n) begin
                    check("a_data", mac.A_data, ref_a[a_cnt]);
                    check("a_last", mac.A_last, a_cnt == n - 1);
                end
                if (a_cnt == n - 1) a_last_k = k;
                a_cnt++; a_pend = 0;
            end else begin
                a_pend = mac.A_valid; a_prev = mac.A_data;
            end
            if (mac.B_valid && mac.B_ready) begin
                if (b_cnt < n) begin
                    check("b_data", mac.B_data, ref_b[b_cnt]);
                    check("b_last", mac.B_last, b_cnt == n - 1);
                end
                if (b_cnt == n - 1) b_last_k = k;
                b_cnt++; b_pend = 0;
            end else begin
                b_pend = mac.B_valid; b_prev = mac.B_data;
            end
            k++;
            @(negedge clk);
        end
        wr_en = 1'b0; start = 1'b0;
        check("wait_entered", entered, 1);
        check("a_count", a_cnt, n);
        check("b_count", b_cnt, n);
        if (!entered) begin
            reset = 1'b1; @(negedge clk); reset = 1'b0; op_active = 0;
            return;
        end
        for (int i = 0; i < n; i++)
            acc += longint'($signed(ref_a[i])) * longint'($signed(ref_b[i]));
        rexp = WR'(acc);
        nb = $urandom_range(0, 2);
        for (int i = 0; i < nb; i++) begin
            v = WR'({$urandom, $urandom});
            mac.R_valid = 1'b1; mac.R_data = v; mac.R_last = 1'b0;
            @(posedge clk); #1;
            check("r_partial", result, v);
            mac.R_valid = 1'b0;
            @(posedge clk); #1;
            check("r_wait_busy", {busy, mac.R_ready}, 2'b11);
        end
        mac.R_valid = 1'b1; mac.R_data = rexp; mac.R_last = 1'b1;
        @(posedge clk); #1;
        check("done_pulse", done, 1);
        check("result", result, rexp);
        check("done_r_ready", {busy, mac.R_ready}, 2'b00);
        // A beat offered outside WAIT_RES must not be captured.
        mac.R_data = ~rexp;
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("result_hold", result, rexp);
        mac.R_valid = 1'b0; mac.R_last = 1'b0;
        op_active = 0;
        $display("op len=%0d a_last@%0d b_last@%0d result=%0h", n, a_last_k, b_last_k, result);
        @(negedge clk);
    endtask

    task automatic bad_start(input int n);
        @(negedge clk);
        start = 1'b1; len = (AW+1)'(n);
        @(negedge clk);
        start = 1'b0;
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_idle", {busy, mac.A_valid, mac.B_valid}, 3'b000);
        @(negedge clk);
        check("cfg_err_single", cfg_err, 0);
        check("cfg_err_still_idle", {busy, mac.A_valid, mac.B_valid}, 3'b000);
        $display("bad start len=%0d", n);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0; start = 1'b0; len = '0;
        mac.A_ready = 1'b0; mac.B_ready = 1'b0;
        mac.R_valid = 1'b0; mac.R_data = '0; mac.R_last = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_flags", {busy, done, cfg_err, mac.A_valid, mac.B_valid}, 5'b0);
        check("rst_lasts", {mac.A_last, mac.B_last, mac.R_ready}, 3'b0);
        check("rst_result", result, 0);

        // Directed dot product: {1,2,3,4}.{5,6,7,8} = 70.
        for (int i = 0; i < 4; i++) write_word(i, WA'(i + 1), WB'(i + 5));
        run_op(4, 0, 0, 0);
        check("dot70", result, 70);
        check("a_last_cycle", a_last_k, 5);
        check("b_last_cycle", b_last_k, 5);

        // A throttled, B free-running: B completes first.
        run_op(4, 1, 0, 0);
        check("b_before_a", b_last_k < a_last_k, 1);

        bad_start(0);
        bad_start(17);

        // Reset once two elements have gone out; restart replays from index 0.
        @(negedge clk);
        start = 1'b1; len = 5'd4; mac.A_ready = 1'b1; mac.B_ready = 1'b1; op_active = 1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_valids", {mac.A_valid, mac.B_valid, busy}, 3'b000);
        reset = 1'b0; op_active = 0;
        $display("reset mid-operation");
        run_op(4, 0, 0, 0);
        check("replay70", result, 70);

        // Randomised runs; odd runs also attempt a write and a start while busy.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < DEPTH; i++)
                if ($urandom_range(0, 1) == 1 || r == 0) write_word(i, WA'($urandom), WB'($urandom));
            run_op(n, 2, 2, r[0]);
        end
        run_op(DEPTH, 2, 2, 0);

`ifdef MAC_SRC_TIMEOUT_EN
        begin
            int cyc = 0;
            bit saw_done = 0;
            @(negedge clk);
            start = 1'b1; len = 5'd1; mac.A_ready = 1'b1; mac.B_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (!mac.R_ready && cyc < 20) begin @(negedge clk); cyc++; end
            cyc = 1;
            while (!cfg_err && cyc < 70000) begin
                @(negedge clk); cyc++;
                if (done) saw_done = 1;
            end
            check("timeout_cycles", cyc, 65536);
            check("timeout_no_done", saw_done, 0);
            check("timeout_idle", {busy, mac.R_ready}, 2'b00);
            check("timeout_result", result, ~WR'(0) & result);
            $display("timeout after %0d cycles", cyc);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
